// File: rtl/ledmate_cmd_parser_if.sv
// Byte-stream and framebuffer bus between the LEDmate command parser and its neighbours.
// master: the UART/framebuffer side; slave: the parser.
interface ledmate_cmd_parser_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_wdata;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/ledmate_cmd_parser.sv
// LEDmate command parser: decodes A5-framed UART commands into framebuffer writes/fills
// and answers each completed command with a one-byte reply.
module ledmate_cmd_parser #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input logic                 clk_48mhz,
  input logic                 reset,
  ledmate_cmd_parser_if.slave bus
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_FILL  = 8'h02;
  localparam logic [7:0]  CMD_PING  = 8'h03;
  localparam logic [7:0]  REPLY_ERR = 8'hEE;

  typedef enum logic [2:0] {IDLE, CMD, ARGS, EXEC, FILL, ACK} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       args_q, args_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]       fb_wdata_q, fb_wdata_d;

  logic              rx_acc_c;
  logic              tmo_hit_c;
  logic [39:0]       args_word_c;

  assign rx_acc_c    = bus.rx_valid && rx_ready_q;
  assign tmo_hit_c   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  // Arguments shift in MSB-first; the final byte comes straight off the bus.
  assign args_word_c = {args_q, bus.rx_data};

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      args_q     <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      args_q     <= args_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    args_d     = args_q;
    tmo_d      = '0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (rx_acc_c && bus.rx_data == SYNC) state_d = CMD;
      end
      CMD: begin
        if (rx_acc_c) begin
          cmd_d = bus.rx_data;
          case (bus.rx_data)
            CMD_WRITE: begin cnt_d = 3'd5; state_d = ARGS; end
            CMD_FILL:  begin cnt_d = 3'd3; state_d = ARGS; end
            CMD_PING:  begin tx_valid_d = 1'b1; tx_data_d = CMD_PING | 8'h80; state_d = ACK; end
            default:   begin tx_valid_d = 1'b1; tx_data_d = REPLY_ERR; state_d = ACK; end
          endcase
        end else if (tmo_hit_c) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ARGS: begin
        if (rx_acc_c) begin
          args_d = args_word_c[31:0];
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            fb_we_d    = 1'b1;
            fb_wdata_d = args_word_c[23:0];
            if (cmd_q == CMD_WRITE) begin
              fb_addr_d = ADDR_W'(args_word_c[39:24]);
              state_d   = EXEC;
            end else begin
              fb_addr_d = '0;
              state_d   = FILL;
            end
          end
        end else if (tmo_hit_c) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      EXEC: begin
        tx_valid_d = 1'b1;
        tx_data_d  = cmd_q | 8'h80;
        state_d    = ACK;
      end
      FILL: begin
        // Stop on the last address so the sweep never wraps back to 0.
        if (fb_addr_q == '1) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_q | 8'h80;
          state_d    = ACK;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_addr_q + ADDR_W'(1);
        end
      end
      ACK: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == IDLE) || (state_d == CMD) || (state_d == ARGS);
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_wdata = fb_wdata_q;

endmodule

// File: tb/tb_ledmate_cmd_parser.sv
// Bench for ledmate_cmd_parser: directed command streams plus randomized traffic
// compared against a byte-level command model.
module tb_ledmate_cmd_parser;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TMO    = 40;
  localparam int unsigned NPIX   = 1 << ADDR_W;

  logic clk_48mhz = 1'b0;
  logic reset;

  ledmate_cmd_parser_if #(.ADDR_W(ADDR_W)) bus();

  ledmate_cmd_parser #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .bus       (bus)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected and observed traffic; write entries are {addr(8), rgb(24)}.
  logic [31:0] exp_wr[$];
  logic [31:0] obs_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];

  // Reference model: walks the accepted byte stream with the command rules.
  int         m_st = 0;   // 0 waiting for sync, 1 expecting command, 2 collecting args
  logic [7:0] m_cmd;
  int         m_need;
  logic [7:0] m_args[$];

  task automatic model_byte(input logic [7:0] b, input int gap);
    int a;
    if (m_st != 0 && gap >= int'(TMO)) m_st = 0;
    case (m_st)
      0: if (b == 8'hA5) m_st = 1;
      1: begin
        m_cmd = b;
        m_args.delete();
        m_st = 0;
        if (b == 8'h01) begin m_need = 5; m_st = 2; end
        else if (b == 8'h02) begin m_need = 3; m_st = 2; end
        else if (b == 8'h03) exp_tx.push_back(8'h83);
        else exp_tx.push_back(8'hEE);
      end
      default: begin
        m_args.push_back(b);
        m_need--;
        if (m_need == 0) begin
          if (m_cmd == 8'h01) begin
            a = (int'(m_args[0]) * 256 + int'(m_args[1])) % int'(NPIX);
            exp_wr.push_back({8'(a), m_args[2], m_args[3], m_args[4]});
            exp_tx.push_back(8'h81);
          end else begin
            for (int i = 0; i < int'(NPIX); i++)
              exp_wr.push_back({8'(i), m_args[0], m_args[1], m_args[2]});
            exp_tx.push_back(8'h82);
          end
          m_st = 0;
        end
      end
    endcase
  endtask

  // tx_ready policy: 0 held low, 1 held high, 2 random
  int tr_mode = 1;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk_48mhz);
      #1;
      if (tr_mode == 0)      bus.tx_ready = 1'b0;
      else if (tr_mode == 1) bus.tx_ready = 1'b1;
      else                   bus.tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Protocol monitor, sampled mid-cycle.
  bit                p_acc, p_we, p_txv, p_txr, p_hold_ok, acc;
  logic [7:0]        p_txd;
  logic [ADDR_W-1:0] p_addr;
  logic [23:0]       p_wd;
  int                n_we = 0;
  int                n_tx = 0;

  always @(negedge clk_48mhz) begin
    if (reset) begin
      p_acc = 0; p_we = 0; p_txv = 0; p_txr = 0; p_hold_ok = 0;
    end else begin
      acc = bus.rx_valid && bus.rx_ready;
      if (bus.fb_we) begin
        obs_wr.push_back({8'(bus.fb_addr), bus.fb_wdata});
        n_we++;
        check("rx_ready_during_write", 32'(bus.rx_ready), 32'd0);
        check("tx_valid_during_write", 32'(bus.tx_valid), 32'd0);
        if (!p_we) check("fb_we_latency", 32'(p_acc), 32'd1);
      end else if (p_hold_ok) begin
        check("fb_addr_hold", 32'(bus.fb_addr), 32'(p_addr));
        check("fb_wdata_hold", 32'(bus.fb_wdata), 32'(p_wd));
      end
      if (bus.tx_valid && !p_txv) check("tx_valid_latency", 32'(p_we | p_acc), 32'd1);
      if (p_txv && !p_txr) begin
        check("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
        check("tx_data_hold", 32'(bus.tx_data), 32'(p_txd));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        obs_tx.push_back(bus.tx_data);
        n_tx++;
      end
      p_acc = acc; p_we = bus.fb_we; p_txv = bus.tx_valid; p_txr = bus.tx_ready;
      p_txd = bus.tx_data; p_addr = bus.fb_addr; p_wd = bus.fb_wdata; p_hold_ok = 1;
    end
  end

  // Offer one byte after 'gap' idle cycles and wait (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done = 0;
    int waited = 0;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk_48mhz); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!done && waited < 600) begin
      @(negedge clk_48mhz);
      done = bus.rx_ready;
      @(posedge clk_48mhz);
      #1;
      waited++;
    end
    bus.rx_valid = 1'b0;
    check("rx_accept", 32'(done), 32'd1);
    if (done) model_byte(b, gap);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 0);
  endtask

  // Wait (bounded) until observed traffic catches up, then compare against the model.
  task automatic drain(input string tag);
    int w = 0;
    while ((obs_tx.size() < exp_tx.size() || obs_wr.size() < exp_wr.size()) && w < 2000) begin
      @(posedge clk_48mhz); #1; w++;
    end
    repeat (4) begin @(posedge clk_48mhz); #1; end
    check({tag, "_wr_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    check({tag, "_tx_count"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
      check({tag, "_tx"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
  endtask

  task automatic flush();
    obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  function automatic int rand_gap();
    int r = $urandom_range(0, 19);
    if (r < 16) return $urandom_range(0, 2);
    return int'(TMO) - 1 + $urandom_range(0, 2);
  endfunction

  function automatic logic [7:0] rand_arg();
    if ($urandom_range(0, 7) == 0) return 8'hA5;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    m_st  = 0;
    repeat (2) @(posedge clk_48mhz);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int w, we0, tx0, kind;
    logic [7:0] b;
    logic [7:0] s[$];
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values
    #35;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_fb_we", 32'(bus.fb_we), 32'd0);
    check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(bus.fb_wdata), 32'd0);
    @(posedge clk_48mhz); #1 reset = 1'b0;
    @(posedge clk_48mhz); #1;
    check("rx_ready_after_reset", 32'(bus.rx_ready), 32'd1);

    // Single pixel write; 0x0123 truncates to address 3
    s = '{8'hA5, 8'h01, 8'h01, 8'h23, 8'hFF, 8'h00, 8'h80};
    send_seq(s);
    drain("write");
    check("write_entry", obs_wr.size() > 0 ? obs_wr[0] : 32'hDEAD, {8'h03, 24'hFF0080});
    check("write_reply", obs_tx.size() > 0 ? 32'(obs_tx[0]) : 32'hDEAD, 32'h81);
    flush();

    // Full-frame fill
    s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30};
    send_seq(s);
    drain("fill");
    check("fill_count", 32'(obs_wr.size()), 32'(NPIX));
    check("fill_last", obs_wr.size() > 0 ? obs_wr[obs_wr.size()-1] : 32'hDEAD, {8'h0F, 24'h102030});
    check("fill_reply", obs_tx.size() > 0 ? 32'(obs_tx[0]) : 32'hDEAD, 32'h82);
    flush();

    // Ping with tx_ready stalled for 10 cycles
    tr_mode = 0;
    s = '{8'h00, 8'hA5, 8'h03};
    send_seq(s);
    w = 0;
    while (!bus.tx_valid && w < 50) begin @(negedge clk_48mhz); w++; end
    repeat (10) begin
      @(negedge clk_48mhz);
      check("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("stall_tx_data", 32'(bus.tx_data), 32'h83);
    end
    tr_mode = 1;
    drain("ping");
    check("ping_one_transfer", 32'(obs_tx.size()), 32'd1);
    check("ping_back_idle", 32'(bus.rx_ready), 32'd1);
    flush();

    // Unknown command then ping
    s = '{8'hA5, 8'h07, 8'hA5, 8'h03};
    send_seq(s);
    drain("unknown");
    check("unknown_reply", obs_tx.size() > 0 ? 32'(obs_tx[0]) : 32'hDEAD, 32'hEE);
    check("unknown_no_write", 32'(obs_wr.size()), 32'd0);
    flush();

    // Timeout abort, then just-under-timeout continuation
    s = '{8'hA5, 8'h01, 8'h01};
    send_seq(s);
    send_byte(8'hA5, int'(TMO));
    send_byte(8'h03, 0);
    drain("timeout");
    check("timeout_no_write", 32'(obs_wr.size()), 32'd0);
    check("timeout_reply", obs_tx.size() > 0 ? 32'(obs_tx[0]) : 32'hDEAD, 32'h83);
    flush();
    s = '{8'hA5, 8'h01, 8'h00};
    send_seq(s);
    send_byte(8'h05, int'(TMO) - 1);
    s = '{8'h11, 8'h22, 8'h33};
    send_seq(s);
    drain("near_timeout");
    check("near_timeout_entry", obs_wr.size() > 0 ? obs_wr[0] : 32'hDEAD, {8'h05, 24'h112233});
    flush();

    // Reset in the middle of a fill
    s = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_seq(s);
    w = 0;
    while (!(bus.fb_we && bus.fb_addr == ADDR_W'(5)) && w < 50) begin @(negedge clk_48mhz); w++; end
    #2 reset = 1'b1;
    m_st = 0;
    #1;
    check("midfill_rst_fb_we", 32'(bus.fb_we), 32'd0);
    check("midfill_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("midfill_writes", 32'(obs_wr.size()), 32'd6);
    repeat (2) @(posedge clk_48mhz);
    #1 reset = 1'b0;
    check("midfill_rx_ready", 32'(bus.rx_ready), 32'd1);
    we0 = n_we; tx0 = n_tx;
    repeat (40) begin @(posedge clk_48mhz); #1; end
    check("midfill_no_more_we", 32'(n_we), 32'(we0));
    check("midfill_no_tx", 32'(n_tx), 32'(tx0));
    flush();

    // Reset while a reply is pending
    tr_mode = 0;
    s = '{8'hA5, 8'h03};
    send_seq(s);
    repeat (3) begin @(posedge clk_48mhz); #1; end
    check("midack_tx_valid_before", 32'(bus.tx_valid), 32'd1);
    pulse_reset();
    tr_mode = 1;
    tx0 = n_tx;
    repeat (20) begin @(posedge clk_48mhz); #1; end
    check("midack_no_tx", 32'(n_tx), 32'(tx0));
    check("midack_tx_valid", 32'(bus.tx_valid), 32'd0);
    flush();

    // Randomized traffic
    tr_mode = 2;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: send_byte(8'($urandom_range(0, 255)), rand_gap());
        1: begin
          send_byte(8'hA5, rand_gap()); send_byte(8'h01, rand_gap());
          for (int k = 0; k < 5; k++) send_byte(rand_arg(), rand_gap());
        end
        2: begin
          send_byte(8'hA5, rand_gap()); send_byte(8'h02, rand_gap());
          for (int k = 0; k < 3; k++) send_byte(rand_arg(), rand_gap());
        end
        3: begin send_byte(8'hA5, rand_gap()); send_byte(8'h03, rand_gap()); end
        4: begin
          b = 8'($urandom_range(0, 255));
          if (b >= 8'h01 && b <= 8'h03) b = 8'hA5;
          send_byte(8'hA5, rand_gap()); send_byte(b, rand_gap());
        end
        default: begin
          send_byte(8'hA5, rand_gap()); send_byte(8'h01, rand_gap());
          for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(rand_arg(), rand_gap());
        end
      endcase
    end
    drain("random");
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
